// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its icache, lsb and RAM sides.
// slave: arbiter view; master: surrounding system (requesters, RAM, control).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Global control
  logic              rdy;
  logic              flush;
  logic              io_buffer_full;
  // Icache fetch port
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic [31:0]       ic_data;
  // Load/store buffer port
  logic              lsb_req;
  logic              lsb_wr;
  logic [1:0]        lsb_len;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_wdata;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;
  // Byte-wide RAM/IO port
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport slave (
    input  rdy, flush, io_buffer_full,
    input  ic_req, ic_addr,
    output ic_done, ic_data,
    input  lsb_req, lsb_wr, lsb_len,
    input  lsb_addr, lsb_wdata,
    output lsb_done, lsb_rdata,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, flush, io_buffer_full,
    output ic_req, ic_addr,
    input  ic_done, ic_data,
    output lsb_req, lsb_wr, lsb_len,
    output lsb_addr, lsb_wdata,
    input  lsb_done, lsb_rdata,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the shared RAM/IO port (icache refill + lsb).
// Ports: clk, rst (async high), bus (mem_arbiter_if.slave: ctl/ic/lsb/mem).
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              own_ic_q, own_ic_d;
  logic              last_lsb_q, last_lsb_d;
  logic              ic_done_q, ic_done_d;
  logic              lsb_done_q, lsb_done_d;

  logic       ic_el;
  logic       lsb_el;
  logic       io_stall;
  logic       pick_ic;
  logic [1:0] bidx;
  logic       addr_on;

  // An IO store cannot start while the IO buffer is full.
  assign io_stall = bus.lsb_wr
                  & (bus.lsb_addr[17:16] == IO_HI)
                  & bus.io_buffer_full;
  assign ic_el  = bus.ic_req;
  assign lsb_el = bus.lsb_req & ~io_stall;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    own_ic_d   = own_ic_q;
    last_lsb_d = last_lsb_q;
    ic_done_d  = 1'b0;
    lsb_done_d = 1'b0;
    pick_ic    = 1'b0;
    // Byte returned this cycle belongs to the address issued last cycle.
    bidx       = cnt_q[1:0] - 2'd1;
    unique case (state_q)
      IDLE: begin
        // Requesters drop req on seeing done, so skip that cycle.
        if (~ic_done_q & ~lsb_done_q & ~bus.flush
            & (ic_el | lsb_el)) begin
          pick_ic    = ic_el & (~lsb_el | last_lsb_q);
          cnt_d      = 3'd0;
          data_d     = 32'h0;
          own_ic_d   = pick_ic;
          last_lsb_d = ~pick_ic;
          if (pick_ic) begin
            base_d  = bus.ic_addr;
            n_d     = 3'd4;
            state_d = READ;
          end else begin
            base_d  = bus.lsb_addr;
            wdata_d = bus.lsb_wdata;
            n_d     = {1'b0, bus.lsb_len} + 3'd1;
            state_d = bus.lsb_wr ? WRITE : READ;
          end
        end
      end
      READ: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            data_d[{bidx, 3'b000} +: 8] = bus.mem_din;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == n_q) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            ic_done_d  = own_ic_q;
            lsb_done_d = ~own_ic_q;
          end
        end
      end
      WRITE: begin
        // Committed stores ignore flush.
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == n_q - 3'd1) begin
          state_d    = IDLE;
          cnt_d      = 3'd0;
          lsb_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      base_q     <= '0;
      wdata_q    <= 32'h0;
      data_q     <= 32'h0;
      own_ic_q   <= 1'b0;
      last_lsb_q <= 1'b1;
      ic_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
    end else if (bus.rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      own_ic_q   <= own_ic_d;
      last_lsb_q <= last_lsb_d;
      ic_done_q  <= ic_done_d;
      lsb_done_q <= lsb_done_d;
    end
  end

  // READ spends one extra cycle (cnt == n) collecting the last byte.
  assign addr_on = (state_q == WRITE)
                 | ((state_q == READ) & (cnt_q < n_q));

  assign bus.mem_a    = addr_on ? base_q + ADDR_W'(cnt_q) : '0;
  assign bus.mem_dout = (state_q == WRITE)
                      ? wdata_q[{cnt_q[1:0], 3'b000} +: 8]
                      : 8'h00;
  assign bus.mem_wr   = (state_q == WRITE) & bus.rdy;

  assign bus.ic_done   = ic_done_q & bus.rdy;
  assign bus.lsb_done  = lsb_done_q & bus.rdy;
  assign bus.ic_data   = data_q;
  assign bus.lsb_rdata = data_q;

endmodule
